gsim_ctrl: RTL and testbench

GSIM_CTRL -- requirements
Module: gsim_ctrl

---
 rtl/gsim_pkg.sv | 17 +
 rtl/gsim_wrap_cnt.sv | 39 +++
 rtl/gsim_ctrl.sv | 131 +++++++++++++
 tb/tb_gsim_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel solver controller and its datapath:
// default geometry, counter width and the controller state encoding.
package gsim_pkg;

    localparam int N_ROW_DEF   = 16;
    localparam int N_STAGE_DEF = 10;
    localparam int ITER_W_DEF  = 7;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_OUT  = 2'd3
    } gsim_state_e;

endpackage

// File: rtl/gsim_wrap_cnt.sv
// Wrapping up-counter: clear has priority, counts on enable, returns to zero
// after wrap_val and flags that wrap with a same-cycle pulse.
module gsim_wrap_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] wrap_val,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_r;
    logic         wrap_s;

    assign wrap_s = en & (cnt_r == wrap_val);
    assign wrap   = wrap_s;
    assign cnt    = cnt_r;

    // Count register with async reset and synchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (wrap_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + W'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/gsim_ctrl.sv
// Gauss-Seidel solver sequencer: loads the b vector, walks rows/stages for the
// requested number of iterations, then streams the x vector downstream.
module gsim_ctrl
    import gsim_pkg::*;
#(
    parameter int N_ROW   = N_ROW_DEF,
    parameter int N_STAGE = N_STAGE_DEF,
    parameter int ITER_W  = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_num,
    input  logic              in_en,
    input  logic              hold,
    output logic              busy,
    output logic              load_we,
    output logic [3:0]        load_idx,
    output logic [3:0]        row,
    output logic [3:0]        stage,
    output logic              x_we,
    output logic [ITER_W-1:0] iter,
    output logic              out_valid,
    output logic [3:0]        out_idx,
    output logic              done
);

    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(N_ROW - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(N_STAGE - 1);

    gsim_state_e       state_r;
    gsim_state_e       state_s;
    logic [ITER_W-1:0] iter_lim_r;
    logic [ITER_W-1:0] iter_r;

    logic start_acc_s, calc_run_s, load_en_s, out_en_s, iter_last_s;
    logic [CNT_W-1:0] stage_r, row_r, load_r, out_r;
    logic stage_wrap_s, row_wrap_s, load_wrap_s, out_wrap_s;

    assign start_acc_s = (state_r == ST_IDLE) & start;
    assign calc_run_s  = (state_r == ST_CALC) & ~hold;
    assign load_en_s   = (state_r == ST_LOAD) & in_en;
    assign out_en_s    = (state_r == ST_OUT);
    assign iter_last_s = (iter_r == (iter_lim_r - ITER_W'(1'b1)));

    // Every counter wraps back to zero on leaving its state, so it reads 0 elsewhere
    gsim_wrap_cnt #(.W(CNT_W)) u_stage_cnt (
        .clk(clk), .reset(reset), .en(calc_run_s), .clr(start_acc_s),
        .wrap_val(STAGE_LAST), .cnt(stage_r), .wrap(stage_wrap_s)
    );

    gsim_wrap_cnt #(.W(CNT_W)) u_row_cnt (
        .clk(clk), .reset(reset), .en(stage_wrap_s), .clr(start_acc_s),
        .wrap_val(ROW_LAST), .cnt(row_r), .wrap(row_wrap_s)
    );

    gsim_wrap_cnt #(.W(CNT_W)) u_load_cnt (
        .clk(clk), .reset(reset), .en(load_en_s), .clr(start_acc_s),
        .wrap_val(ROW_LAST), .cnt(load_r), .wrap(load_wrap_s)
    );

    gsim_wrap_cnt #(.W(CNT_W)) u_out_cnt (
        .clk(clk), .reset(reset), .en(out_en_s), .clr(start_acc_s),
        .wrap_val(ROW_LAST), .cnt(out_r), .wrap(out_wrap_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_wrap_s) state_s = ST_CALC;
                else             state_s = ST_LOAD;
            end
            ST_CALC: begin
                if (row_wrap_s && iter_last_s) state_s = ST_OUT;
                else                           state_s = ST_CALC;
            end
            ST_OUT: begin
                if (out_wrap_s) state_s = ST_OUT == ST_OUT ? ST_IDLE : ST_IDLE;
                else            state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Iteration limit and completed-iteration count; iter persists until the next start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_lim_r <= ITER_W'(1'b1);
            iter_r     <= '0;
        end else if (start_acc_s) begin
            iter_lim_r <= (iter_num == '0) ? ITER_W'(1'b1) : iter_num;
            iter_r     <= '0;
        end else if (row_wrap_s) begin
            iter_lim_r <= iter_lim_r;
            iter_r     <= iter_r + ITER_W'(1'b1);
        end else begin
            iter_lim_r <= iter_lim_r;
            iter_r     <= iter_r;
        end
    end

    // Output decode; hold only gates the write-back strobe of a frozen last stage
    always_comb begin
        busy      = (state_r != ST_IDLE);
        load_we   = (state_r == ST_LOAD) & in_en;
        load_idx  = load_r;
        row       = row_r;
        stage     = stage_r;
        x_we      = (state_r == ST_CALC) & (stage_r == STAGE_LAST) & ~hold;
        iter      = iter_r;
        out_valid = (state_r == ST_OUT);
        out_idx   = out_r;
        done      = (state_r == ST_OUT) & (out_r == ROW_LAST);
    end

endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed self-checking bench for gsim_ctrl: full solves, iter_num=0, gapped
// loading, hold, ignored starts and an asynchronous reset in mid-CALC.
module tb_gsim_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] iter_num;
    logic       in_en;
    logic       hold;
    logic       busy;
    logic       load_we;
    logic [3:0] load_idx;
    logic [3:0] row;
    logic [3:0] stage;
    logic       x_we;
    logic [6:0] iter;
    logic       out_valid;
    logic [3:0] out_idx;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    gsim_ctrl #(.N_ROW(16), .N_STAGE(10), .ITER_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .iter_num(iter_num),
        .in_en(in_en), .hold(hold), .busy(busy), .load_we(load_we),
        .load_idx(load_idx), .row(row), .stage(stage), .x_we(x_we),
        .iter(iter), .out_valid(out_valid), .out_idx(out_idx), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load_we"}, load_we, 0);
        chk({tag, "_x_we"}, x_we, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_load_idx"}, load_idx, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
    endtask

    task automatic do_start(input logic [6:0] inum);
        start = 1'b1;
        iter_num = inum;
        #1;
        chk("start_idle_busy", busy, 0);
        tick();
        start = 1'b0;
        iter_num = 7'd9;
        #1;
        chk("load_busy", busy, 1);
        chk("load_idx0", load_idx, 0);
        chk("load_iter0", iter, 0);
        chk("load_outv", out_valid, 0);
    endtask

    task automatic do_load(input bit toggle);
        int k = 0;
        int c = 0;
        while (k < 16 && c < 100) begin
            in_en = toggle ? ((c % 2) == 0) : 1'b1;
            #1;
            chk("load_we", load_we, in_en);
            chk("load_idx", load_idx, k);
            tick();
            if (in_en) k++;
            c++;
        end
        chk("load_words", k, 16);
        chk("load_cycles", c, toggle ? 31 : 16);
        in_en = 1'b1;
        #1;
        chk("calc_no_load_we", load_we, 0);
        chk("calc_entry_busy", busy, 1);
        chk("calc_entry_row", row, 0);
        chk("calc_entry_stage", stage, 0);
        chk("calc_entry_iter", iter, 0);
        in_en = 1'b0;
    endtask

    task automatic do_calc(input int lim, input bit use_hold, input bit poke, input bit rst7);
        int cyc = 0;
        int held = 0;
        int xw = 0;
        int eff;
        bit hold_done = 1'b0;
        while (!out_valid && cyc < 4000) begin
            if (rst7 && row == 4'd7) begin
                reset = 1'b0;
                #1;
                chk_quiet("rst_calc");
                chk("rst_calc_iter", iter, 0);
                return;
            end
            if (use_hold && !hold_done && row == 4'd3 && stage == 4'd4) begin
                for (int h = 0; h < 5; h++) begin
                    hold = 1'b1;
                    #1;
                    chk("hold_x_we", x_we, 0);
                    chk("hold_row", row, 3);
                    chk("hold_stage", stage, 4);
                    chk("hold_iter", iter, 0);
                    chk("hold_busy", busy, 1);
                    tick();
                    cyc++;
                    held++;
                end
                hold = 1'b0;
                hold_done = 1'b1;
            end else begin
                if (poke && cyc == 50) begin
                    start = 1'b1;
                    iter_num = 7'd5;
                end
                #1;
                eff = cyc - held;
                chk("calc_stage", stage, eff % 10);
                chk("calc_row", row, (eff / 10) % 16);
                chk("calc_iter", iter, eff / 160);
                chk("calc_x_we", x_we, (eff % 10) == 9);
                if (x_we) xw++;
                tick();
                cyc++;
                start = 1'b0;
            end
        end
        chk("calc_cycles", cyc, 160 * lim + (use_hold ? 5 : 0));
        chk("calc_x_we_count", xw, 16 * lim);
    endtask

    task automatic do_out(input int lim, input bit poke);
        for (int k = 0; k < 16; k++) begin
            if (poke && k == 5) begin
                start = 1'b1;
                iter_num = 7'd4;
            end
            #1;
            chk("out_valid", out_valid, 1);
            chk("out_idx", out_idx, k);
            chk("out_done", done, k == 15);
            chk("out_row", row, 0);
            chk("out_iter", iter, lim);
            tick();
            start = 1'b0;
        end
        #1;
        chk_quiet("idle_after_out");
        chk("idle_iter", iter, lim);
        tick();
        #1;
        chk("idle_stays_busy", busy, 0);
        chk("idle_stays_iter", iter, lim);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        iter_num = 7'd0;
        in_en = 1'b0;
        hold = 1'b0;
        #12;
        chk_quiet("reset");
        chk("reset_iter", iter, 0);
        tick();
        reset = 1'b1;
        hold = 1'b1;
        in_en = 1'b1;
        #1;
        chk_quiet("idle_inputs_ignored");
        hold = 1'b0;
        in_en = 1'b0;
        tick();

        // two iterations, back-to-back load
        do_start(7'd2);
        do_load(1'b0);
        do_calc(2, 1'b0, 1'b0, 1'b0);
        do_out(2, 1'b0);

        // iter_num=0 behaves as 1, gapped load, hold at row 3 stage 4
        do_start(7'd0);
        do_load(1'b1);
        do_calc(1, 1'b1, 1'b0, 1'b0);
        do_out(1, 1'b0);

        // starts during CALC and OUT are ignored
        do_start(7'd1);
        do_load(1'b0);
        do_calc(1, 1'b0, 1'b1, 1'b0);
        do_out(1, 1'b1);

        // reset in CALC at row 7, then a normal single-iteration solve
        do_start(7'd3);
        do_load(1'b0);
        do_calc(3, 1'b0, 1'b0, 1'b1);
        tick();
        #1;
        chk_quiet("rst_held");
        reset = 1'b1;
        tick();
        #1;
        chk_quiet("rst_released");
        do_start(7'd1);
        do_load(1'b0);
        do_calc(1, 1'b0, 1'b0, 1'b0);
        do_out(1, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
